lsu_mem_port: RTL and testbench

Load/store unit between the decode/control stage and data memory. It takes the memory-access controls for the current instruction: read/write strobe, `MemType` (word/byte/half) and `MemSign`. It runs one request/grant/response transaction on a word-addressed data bus, generating byte enables and lane-replicated store data. It sign- or zero-extends load data back to the register-file write path and stalls the core until the access completes.

---
 rtl/lsu_mem_port.sv | 142 ++++++++++++++
 tb/tb_lsu_mem_port.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store unit that drives one req/gnt/rvalid data-bus transaction per
// memory instruction. Optional MISALIGN_TRAP_EN faults misaligned accesses.
module lsu_mem_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic [1:0]            MemType_i,
  input  logic                  MemSign_i,
  input  logic [ADDR_WIDTH-1:0] Addr_i,
  input  logic [DATA_WIDTH-1:0] WriteData_i,
  output logic [DATA_WIDTH-1:0] ReadData_o,
  output logic                  Stall_o,
  output logic                  Fault_o,
  output logic                  BusReq_o,
  output logic                  BusWe_o,
  output logic [ADDR_WIDTH-1:0] BusAddr_o,
  output logic [3:0]            BusBe_o,
  output logic [DATA_WIDTH-1:0] BusWData_o,
  input  logic                  BusGnt_i,
  input  logic [DATA_WIDTH-1:0] BusRData_i,
  input  logic                  BusRValid_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  localparam logic [1:0] MT_WORD = 2'b00;
  localparam logic [1:0] MT_BYTE = 2'b01;
  localparam logic [1:0] MT_HALF = 2'b10;

  state_e                  state_q, state_d;
  logic                    req_in, trap;
  logic [1:0]              off;
  logic [3:0]              be_d;
  logic [DATA_WIDTH-1:0]   wdata_d, rdata_ext;
  logic [1:0]              type_q, off_q;
  logic                    sign_q;
  logic                    BusReq_q, BusWe_q, Fault_q;
  logic [ADDR_WIDTH-1:0]   BusAddr_q;
  logic [3:0]              BusBe_q;
  logic [DATA_WIDTH-1:0]   BusWData_q, ReadData_q;

  assign req_in = MemRead_i | MemWrite_i;
  assign off    = Addr_i[1:0];

`ifdef MISALIGN_TRAP_EN
  assign trap = (MemType_i == MT_HALF) ? off[0] :
                (MemType_i == MT_BYTE) ? 1'b0   : (off != 2'b00);
`else
  assign trap = 1'b0;
`endif

  // Store lane placement; misaligned low bits are dropped when not trapping.
  always_comb begin
    be_d    = 4'hF;
    wdata_d = WriteData_i;
    case (MemType_i)
      MT_BYTE: begin
        be_d    = 4'b0001 << off;
        wdata_d = {4{WriteData_i[7:0]}};
      end
      MT_HALF: begin
        be_d    = off[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{WriteData_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata_ext = BusRData_i;
    case (type_q)
      MT_BYTE: rdata_ext = {{24{~sign_q & BusRData_i[{off_q, 3'b111}]}},
                            BusRData_i[{off_q, 3'b000} +: 8]};
      MT_HALF: rdata_ext = {{16{~sign_q & BusRData_i[{off_q[1], 4'b1111}]}},
                            BusRData_i[{off_q[1], 4'b0000} +: 16]};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_in) state_d = trap ? DONE : REQ;
      REQ:  if (BusGnt_i) state_d = BusWe_q ? DONE : WAIT;
      WAIT: if (BusRValid_i) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      type_q     <= MT_WORD;
      off_q      <= 2'b00;
      sign_q     <= 1'b0;
      BusReq_q   <= 1'b0;
      BusWe_q    <= 1'b0;
      BusAddr_q  <= '0;
      BusBe_q    <= 4'h0;
      BusWData_q <= '0;
      ReadData_q <= '0;
      Fault_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      Fault_q <= 1'b0;
      case (state_q)
        IDLE: if (req_in) begin
          type_q  <= MemType_i;
          off_q   <= off;
          sign_q  <= MemSign_i;
          Fault_q <= trap;
          if (!trap) begin
            // Store wins when both strobes are set.
            BusReq_q   <= 1'b1;
            BusWe_q    <= MemWrite_i;
            BusAddr_q  <= {Addr_i[ADDR_WIDTH-1:2], 2'b00};
            BusBe_q    <= MemWrite_i ? be_d : 4'hF;
            BusWData_q <= wdata_d;
          end
        end
        REQ:  if (BusGnt_i) BusReq_q <= 1'b0;
        WAIT: if (BusRValid_i) ReadData_q <= rdata_ext;
        default: ;
      endcase
    end
  end

  assign Stall_o    = ((state_q == IDLE) && req_in) || (state_q == REQ) || (state_q == WAIT);
  assign BusReq_o   = BusReq_q;
  assign BusWe_o    = BusWe_q;
  assign BusAddr_o  = BusAddr_q;
  assign BusBe_o    = BusBe_q;
  assign BusWData_o = BusWData_q;
  assign ReadData_o = ReadData_q;
  assign Fault_o    = Fault_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: vector table on a scripted bus plus
// delayed-bus and mid-transaction reset sequences.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i, MemSign_i;
  logic [1:0]  MemType_i;
  logic [31:0] Addr_i, WriteData_i;
  logic [31:0] ReadData_o;
  logic        Stall_o, Fault_o, BusReq_o, BusWe_o;
  logic [31:0] BusAddr_o, BusWData_o;
  logic [3:0]  BusBe_o;
  logic        BusGnt_i, BusRValid_i;
  logic [31:0] BusRData_i;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_mem_port dut (
    .clk_i(clk), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .MemType_i(MemType_i),
    .MemSign_i(MemSign_i), .Addr_i(Addr_i), .WriteData_i(WriteData_i),
    .ReadData_o(ReadData_o), .Stall_o(Stall_o), .Fault_o(Fault_o),
    .BusReq_o(BusReq_o), .BusWe_o(BusWe_o), .BusAddr_o(BusAddr_o),
    .BusBe_o(BusBe_o), .BusWData_o(BusWData_o), .BusGnt_i(BusGnt_i),
    .BusRData_i(BusRData_i), .BusRValid_i(BusRValid_i)
  );

  typedef struct {
    string       name;
    logic        re, we;
    logic [1:0]  mtype;
    logic        msign;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic [31:0] bwdata, baddr, rd;
    int          stall;
    logic        fault;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Scripted bus: grant after gdly REQ cycles, RValid rdly cycles into WAIT.
  task automatic run_txn(input vec_t v, input int gdly, input int rdly);
    int  scnt, rq, wc;
    bit  gnt_seen, fin;
    MemRead_i = v.re; MemWrite_i = v.we; MemType_i = v.mtype; MemSign_i = v.msign;
    Addr_i = v.addr; WriteData_i = v.wdata; BusRData_i = v.rdata;
    scnt = 0; rq = 0; wc = 0; gnt_seen = 0; fin = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      #1;
      if (!Stall_o) fin = 1;
      else begin
        scnt++;
        if (BusReq_o) begin
          check({v.name, "/we"}, BusWe_o, v.we);
          check({v.name, "/addr"}, BusAddr_o, v.baddr);
          check({v.name, "/be"}, BusBe_o, v.be);
          if (v.we) check({v.name, "/wdata"}, BusWData_o, v.bwdata);
          if (rq == gdly) begin BusGnt_i = 1'b1; gnt_seen = 1; end
          rq++;
        end else if (gnt_seen) begin
          if (wc == rdly) BusRValid_i = 1'b1;
          wc++;
        end
        @(posedge clk); #1;
        BusGnt_i = 1'b0; BusRValid_i = 1'b0;
      end
    end
    if (!fin) begin
      checks++; failures++;
      $display("FAIL %s/timeout actual=stalled required=done", v.name);
    end
    check({v.name, "/stall_cycles"}, scnt, v.stall);
    check({v.name, "/bus_requests"}, rq, (v.fault ? 0 : gdly + 1));
    check({v.name, "/rdata"}, ReadData_o, v.rd);
    check({v.name, "/fault"}, Fault_o, v.fault);
    check({v.name, "/done_req"}, BusReq_o, 1'b0);
    // Request still held through DONE must not be reissued.
    @(posedge clk); #1;
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
    #1;
    check({v.name, "/idle_req"}, BusReq_o, 1'b0);
    check({v.name, "/idle_stall"}, Stall_o, 1'b0);
    check({v.name, "/idle_fault"}, Fault_o, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = '{"st_byte",    0,1,2'b01,0,32'h1003,32'h000000A5,32'h0,        4'b1000,32'hA5A5A5A5,32'h1000,32'h00000000,2,0};
    vecs[1]  = '{"ld_byte_s",  1,0,2'b01,0,32'h2002,32'h0,32'h00F00000,        4'b1111,32'h0,       32'h2000,32'hFFFFFFF0,3,0};
    vecs[2]  = '{"ld_byte_z",  1,0,2'b01,1,32'h2002,32'h0,32'h00F00000,        4'b1111,32'h0,       32'h2000,32'h000000F0,3,0};
    vecs[3]  = '{"ld_half_s",  1,0,2'b10,0,32'h2002,32'h0,32'h80010000,        4'b1111,32'h0,       32'h2000,32'hFFFF8001,3,0};
    vecs[4]  = '{"ld_word",    1,0,2'b00,0,32'h4000,32'h0,32'hDEADBEEF,        4'b1111,32'h0,       32'h4000,32'hDEADBEEF,3,0};
    vecs[5]  = '{"st_half",    0,1,2'b10,0,32'h1002,32'h0000BEEF,32'h0,        4'b1100,32'hBEEFBEEF,32'h1000,32'hDEADBEEF,2,0};
    vecs[6]  = '{"st_word",    0,1,2'b00,0,32'h1004,32'h12345678,32'h0,        4'b1111,32'h12345678,32'h1004,32'hDEADBEEF,2,0};
    vecs[7]  = '{"st_wins",    1,1,2'b01,0,32'h1001,32'h0000005A,32'h0,        4'b0010,32'h5A5A5A5A,32'h1000,32'hDEADBEEF,2,0};
    vecs[8]  = '{"ld_byte_pos",1,0,2'b01,0,32'h2001,32'h0,32'h00007F00,        4'b1111,32'h0,       32'h2000,32'h0000007F,3,0};
    vecs[9]  = '{"ld_half_z",  1,0,2'b10,1,32'h2000,32'h0,32'h0000FFFE,        4'b1111,32'h0,       32'h2000,32'h0000FFFE,3,0};
    vecs[10] = '{"ld_rsvd",    1,0,2'b11,0,32'h2004,32'h0,32'hCAFEF00D,        4'b1111,32'h0,       32'h2004,32'hCAFEF00D,3,0};
`ifdef MISALIGN_TRAP_EN
    vecs[11] = '{"ld_misalign",1,0,2'b10,1,32'h3001,32'h0,32'h1234ABCD,        4'b1111,32'h0,       32'h3000,32'hCAFEF00D,1,1};
`else
    vecs[11] = '{"ld_misalign",1,0,2'b10,1,32'h3001,32'h0,32'h1234ABCD,        4'b1111,32'h0,       32'h3000,32'h0000ABCD,3,0};
`endif

    rst_i = 1'b1; MemRead_i = 0; MemWrite_i = 0; MemType_i = 0; MemSign_i = 0;
    Addr_i = 0; WriteData_i = 0; BusGnt_i = 0; BusRValid_i = 0; BusRData_i = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/req", BusReq_o, 0);      check("rst/we", BusWe_o, 0);
    check("rst/addr", BusAddr_o, 0);    check("rst/be", BusBe_o, 0);
    check("rst/wdata", BusWData_o, 0);  check("rst/rdata", ReadData_o, 0);
    check("rst/fault", Fault_o, 0);     check("rst/stall", Stall_o, 0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_txn(vecs[i], 0, 0);

    // Grant on the 3rd REQ cycle, RValid three cycles after grant.
    run_txn('{"ld_delayed",1,0,2'b00,0,32'h5000,32'h0,32'h0BADF00D,4'b1111,32'h0,32'h5000,32'h0BADF00D,7,0}, 2, 2);

    // Reset while requesting: BusReq drops without a clock edge.
    MemRead_i = 1; MemType_i = 2'b00; Addr_i = 32'h6000;
    @(posedge clk); #1;
    #1 check("rstreq/pre_req", BusReq_o, 1);
    rst_i = 1'b1; #1;
    check("rstreq/req", BusReq_o, 0);
    check("rstreq/rdata", ReadData_o, 0);
    MemRead_i = 0; #1;
    check("rstreq/stall", Stall_o, 0);
    @(posedge clk); #1; rst_i = 1'b0;
    @(posedge clk); #1;

    // Restore a nonzero ReadData, then reset during WAIT.
    run_txn(vecs[4], 0, 0);
    MemRead_i = 1; MemType_i = 2'b00; Addr_i = 32'h6000;
    @(posedge clk); #1;
    BusGnt_i = 1; @(posedge clk); #1; BusGnt_i = 0;
    #1 check("rstwait/pre_stall", Stall_o, 1);
    check("rstwait/pre_rdata", ReadData_o, 32'hDEADBEEF);
    rst_i = 1'b1; #1;
    check("rstwait/req", BusReq_o, 0);
    check("rstwait/rdata", ReadData_o, 0);
    MemRead_i = 0; #1;
    check("rstwait/stall", Stall_o, 0);
    @(posedge clk); #1; rst_i = 1'b0;
    @(posedge clk); #1;
    BusRValid_i = 1; BusRData_i = 32'hFFFFFFFF;
    @(posedge clk); #1; BusRValid_i = 0;
    @(posedge clk); #1;
    check("late_rvalid/rdata", ReadData_o, 0);
    check("late_rvalid/req", BusReq_o, 0);
    check("late_rvalid/stall", Stall_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
